// File: rtl/qam16_demod_pkg.sv
// rtl/qam16_demod_pkg.sv - 16-QAM symbol type, level constants, Gray map/unmap, slicer, carrier table
package qam16_demod_pkg;

   typedef logic [3:0] sym_t;

   localparam int LVL_M3 = -3;
   localparam int LVL_M1 = -1;
   localparam int LVL_P1 = 1;
   localparam int LVL_P3 = 3;

   function automatic logic [1:0] gray_map(input int lvl);
      case (lvl)
         LVL_M3:  gray_map = 2'b00;
         LVL_M1:  gray_map = 2'b01;
         LVL_P1:  gray_map = 2'b11;
         default: gray_map = 2'b10;
      endcase
   endfunction

   function automatic int gray_unmap(input logic [1:0] bits);
      case (bits)
         2'b00:   gray_unmap = LVL_M3;
         2'b01:   gray_unmap = LVL_M1;
         2'b11:   gray_unmap = LVL_P1;
         default: gray_unmap = LVL_P3;
      endcase
   endfunction

   // Ties resolve upward at +THR and 0, and toward the inner level at -THR.
   function automatic int slice(input longint v, input longint thr);
      if (v >= thr)
         slice = LVL_P3;
      else if (v >= 0)
         slice = LVL_P1;
      else if (v >= -thr)
         slice = LVL_M1;
      else
         slice = LVL_M3;
   endfunction

   function automatic int carrier_cos(input int k, input int depth, input int amp);
      real x;
      x = real'(amp) * $cos(2.0 * 3.14159265358979 * real'(k) / real'(depth));
      if (x >= 0.0)
         carrier_cos = $rtoi(x + 0.5);
      else
         carrier_cos = -$rtoi(-x + 0.5);
   endfunction

endpackage

// File: rtl/qam16_demod_if.sv
// rtl/qam16_demod_if.sv - sample-in / symbol-out bundle; soft outputs present with QAM16_DEMOD_SOFT_EN
interface qam16_demod_if
   import qam16_demod_pkg::*;
#(
   parameter int DIN_W = 30,
   parameter int ACC_W = 48
);
   logic signed [DIN_W-1:0] din;
   logic                    din_vld;
   sym_t                    sym;
   logic                    sym_vld;
`ifdef QAM16_DEMOD_SOFT_EN
   logic signed [ACC_W-1:0] soft_i;
   logic signed [ACC_W-1:0] soft_q;
`endif

   modport master (
      output din, din_vld,
      input  sym, sym_vld
`ifdef QAM16_DEMOD_SOFT_EN
      , input soft_i, soft_q
`endif
   );

   modport slave (
      input  din, din_vld,
      output sym, sym_vld
`ifdef QAM16_DEMOD_SOFT_EN
      , output soft_i, soft_q
`endif
   );
endinterface

// File: rtl/qam16_nco_lut.sv
// rtl/qam16_nco_lut.sv - free-running carrier phase counter with registered cos / -sin lookup
module qam16_nco_lut
   import qam16_demod_pkg::*;
#(
   parameter int NCO_W     = 12,
   parameter int LUT_DEPTH = 16
) (
   input  logic                    CLK,
   input  logic                    Rst,
   input  logic                    advance,
   output logic signed [NCO_W-1:0] cos_out,
   output logic signed [NCO_W-1:0] msin_out
);
   localparam int PH_W = $clog2(LUT_DEPTH);
   localparam int AMP  = (1 << (NCO_W - 1)) - 1;
   localparam logic [PH_W-1:0] QTR = PH_W'(LUT_DEPTH / 4);

   logic signed [NCO_W-1:0] rom [LUT_DEPTH];
   logic [PH_W-1:0]         ph;
   logic [PH_W-1:0]         ph_q;

   for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
      assign rom[k] = NCO_W'(carrier_cos(k, LUT_DEPTH, AMP));
   end

   // -sin(x) == cos(x + pi/2), so a quarter-period offset reuses the cosine table.
   assign ph_q = ph + QTR;

   always_ff @(posedge CLK) begin
      if (Rst) begin
         ph       <= '0;
         cos_out  <= '0;
         msin_out <= '0;
      end else if (advance) begin
         ph       <= ph + 1'b1;
         cos_out  <= rom[ph];
         msin_out <= rom[ph_q];
      end
   end
endmodule

// File: rtl/qam16_demod.sv
// rtl/qam16_demod.sv - coherent 16-QAM demodulator: mix, integrate-and-dump, slice, Gray-decode
// Optional soft-decision outputs: QAM16_DEMOD_SOFT_EN
module qam16_demod
   import qam16_demod_pkg::*;
#(
   parameter int     DIN_W     = 30,
   parameter int     NCO_W     = 12,
   parameter int     LUT_DEPTH = 16,
   parameter int     SPS       = 64,
   parameter int     ACC_W     = DIN_W + NCO_W + $clog2(SPS),
   parameter longint THR       = longint'(1) << 36
) (
   input logic           CLK,
   input logic           Rst,
   qam16_demod_if.slave  bus
);
   localparam int P_W   = DIN_W + NCO_W;
   localparam int CNT_W = $clog2(SPS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

   logic signed [NCO_W-1:0] cos_r, msin_r;
   logic signed [DIN_W-1:0] din_r;
   logic signed [P_W-1:0]   p_i, p_q;
   logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q, hold_i, hold_q;
   logic [CNT_W-1:0]        cnt;
   logic                    v1, v2, hold_vld;
   sym_t                    sym_r;
   logic                    sym_vld_r;

   qam16_nco_lut #(.NCO_W(NCO_W), .LUT_DEPTH(LUT_DEPTH)) u_nco (
      .CLK      (CLK),
      .Rst      (Rst),
      .advance  (bus.din_vld),
      .cos_out  (cos_r),
      .msin_out (msin_r)
   );

   always_ff @(posedge CLK) begin
      if (Rst) begin
         v1    <= 1'b0;
         din_r <= '0;
      end else begin
         v1 <= bus.din_vld;
         if (bus.din_vld)
            din_r <= bus.din;
      end
   end

   always_ff @(posedge CLK) begin
      if (Rst) begin
         v2  <= 1'b0;
         p_i <= '0;
         p_q <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            p_i <= P_W'(din_r) * P_W'(cos_r);
            p_q <= P_W'(din_r) * P_W'(msin_r);
         end
      end
   end

   assign sum_i = acc_i + ACC_W'(p_i);
   assign sum_q = acc_q + ACC_W'(p_q);

   // The last sample of a symbol is folded into the dump so the accumulators restart clean.
   always_ff @(posedge CLK) begin
      if (Rst) begin
         acc_i    <= '0;
         acc_q    <= '0;
         hold_i   <= '0;
         hold_q   <= '0;
         cnt      <= '0;
         hold_vld <= 1'b0;
      end else begin
         hold_vld <= 1'b0;
         if (v2) begin
            if (cnt == LAST) begin
               hold_i   <= sum_i;
               hold_q   <= sum_q;
               acc_i    <= '0;
               acc_q    <= '0;
               cnt      <= '0;
               hold_vld <= 1'b1;
            end else begin
               acc_i <= sum_i;
               acc_q <= sum_q;
               cnt   <= cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Rst) begin
         sym_r     <= '0;
         sym_vld_r <= 1'b0;
      end else begin
         sym_vld_r <= hold_vld;
         if (hold_vld)
            sym_r <= {gray_map(slice(64'(hold_i), THR)), gray_map(slice(64'(hold_q), THR))};
      end
   end

   assign bus.sym     = sym_r;
   assign bus.sym_vld = sym_vld_r;

`ifdef QAM16_DEMOD_SOFT_EN
   logic signed [ACC_W-1:0] soft_i_r, soft_q_r;

   always_ff @(posedge CLK) begin
      if (Rst) begin
         soft_i_r <= '0;
         soft_q_r <= '0;
      end else if (hold_vld) begin
         soft_i_r <= hold_i;
         soft_q_r <= hold_q;
      end
   end

   assign bus.soft_i = soft_i_r;
   assign bus.soft_q = soft_q_r;
`endif
endmodule

// File: tb/tb_qam16_demod.sv
// tb/tb_qam16_demod.sv - scoreboard bench: ideal 16-QAM modulator drives qam16_demod
module tb_qam16_demod;
   localparam int     DIN_W     = 30;
   localparam int     NCO_W     = 12;
   localparam int     LUT_DEPTH = 16;
   localparam int     SPS       = 64;
   localparam int     ACC_W     = DIN_W + NCO_W + $clog2(SPS);
   localparam longint THR       = longint'(1) << 36;
   localparam int     UNIT      = 256;
   localparam int     FS_UNIT   = 61666;
   localparam real    PI        = 3.14159265358979;

   logic CLK = 1'b0;
   logic Rst = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;
   int   strobes = 0;
   int   cyc = 0;
   int   first_strobe_cyc = -1;
   int   t_first = 0;
   logic prev_vld = 1'b0;
   logic [3:0] exp_q [$];
   int   cos_t [LUT_DEPTH];
   int   msin_t [LUT_DEPTH];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   qam16_demod_if #(.DIN_W(DIN_W), .ACC_W(ACC_W)) bus ();

   qam16_demod #(
      .DIN_W(DIN_W), .NCO_W(NCO_W), .LUT_DEPTH(LUT_DEPTH), .SPS(SPS), .ACC_W(ACC_W), .THR(THR)
   ) dut (
      .CLK (CLK),
      .Rst (Rst),
      .bus (bus)
   );

   function automatic int rnd(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   function automatic longint lvl(input logic [1:0] b);
      case (b)
         2'b00:   return -3;
         2'b01:   return -1;
         2'b11:   return 1;
         default: return 3;
      endcase
   endfunction

   task automatic check(input string tag, input longint obs, input longint expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic put(input longint d, input logic v);
      @(posedge CLK);
      #1;
      bus.din     = DIN_W'(d);
      bus.din_vld = v;
   endtask

   task automatic send_sym(input logic [3:0] s, input int unit, input bit bubbles, input bit push,
                           input int nsamp);
      longint ai, aq;
      ai = lvl(s[3:2]) * unit;
      aq = lvl(s[1:0]) * unit;
      if (push) exp_q.push_back(s);
      for (int i = 0; i < nsamp; i++) begin
         while (bubbles && $urandom_range(1, 0) == 1) put(longint'($urandom), 1'b0);
         put(ai * cos_t[i % LUT_DEPTH] + aq * msin_t[i % LUT_DEPTH], 1'b1);
         if (i == 0) t_first = cyc;
      end
   endtask

   // One symbol whose I integral is exactly a*cos[0] + b*(cos[1]+cos[15]) and whose Q integral is 0.
   task automatic send_exact(input longint a, input longint b, input logic [3:0] expv);
      exp_q.push_back(expv);
      for (int i = 0; i < SPS; i++) begin
         if (i == 0)
            put(a, 1'b1);
         else if (i == 1 || i == 15)
            put(b, 1'b1);
         else
            put(0, 1'b1);
      end
      put(0, 1'b0);
   endtask

   task automatic wait_strobes(input string tag, input int target, input int budget);
      int n = 0;
      while (strobes < target && n < budget) begin
         @(posedge CLK);
         n++;
      end
      check(tag, strobes, target);
   endtask

   always @(negedge CLK) begin
      if (bus.sym_vld === 1'b1) begin
         strobes++;
         if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
         check("strobe_width", prev_vld, 0);
         check("sb_not_empty", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("sym", bus.sym, exp_q.pop_front());
      end
      prev_vld = bus.sym_vld;
   end

   initial begin
      int base, t_sym;
      longint a, b, c0, c1;
      for (int k = 0; k < LUT_DEPTH; k++) begin
         cos_t[k]  = rnd(2047.0 * $cos(2.0 * PI * k / LUT_DEPTH));
         msin_t[k] = rnd(-2047.0 * $sin(2.0 * PI * k / LUT_DEPTH));
      end
      bus.din     = '0;
      bus.din_vld = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_sym", bus.sym, 0);
      check("rst_sym_vld", bus.sym_vld, 0);
`ifdef QAM16_DEMOD_SOFT_EN
      check("rst_soft_i", longint'(bus.soft_i), 0);
      check("rst_soft_q", longint'(bus.soft_q), 0);
`endif
      @(posedge CLK);
      #1 Rst = 1'b0;

      // Sweep of all 16 symbols, continuous valid
      base = strobes;
      first_strobe_cyc = -1;
      for (int s = 0; s < 16; s++) begin
         send_sym(4'(s), UNIT, 1'b0, 1'b1, SPS);
         if (s == 0) t_sym = t_first;
      end
      put(0, 1'b0);
      wait_strobes("sweep_count", base + 16, 300);
      check("latency_first", first_strobe_cyc - t_sym + 1, 68);
      repeat (20) @(posedge CLK);
      @(negedge CLK);
      check("sym_hold", bus.sym, 4'hF);

      // Zero input: both axes tie to +1
      base = strobes;
      exp_q.push_back(4'b1111);
      for (int i = 0; i < SPS; i++) put(0, 1'b1);
      put(0, 1'b0);
      wait_strobes("zero_count", base + 1, 200);

      // Full-scale corners
      base = strobes;
      send_sym(4'b0000, FS_UNIT, 1'b0, 1'b1, SPS);
      send_sym(4'b0010, FS_UNIT, 1'b0, 1'b1, SPS);
      send_sym(4'b1000, FS_UNIT, 1'b0, 1'b1, SPS);
      send_sym(4'b1010, FS_UNIT, 1'b0, 1'b1, SPS);
      put(0, 1'b0);
      wait_strobes("corner_count", base + 4, 400);

      // 50% bubbles
      base = strobes;
      send_sym(4'h5, UNIT, 1'b1, 1'b1, SPS);
      send_sym(4'hA, UNIT, 1'b1, 1'b1, SPS);
      send_sym(4'hF, UNIT, 1'b1, 1'b1, SPS);
      send_sym(4'h0, UNIT, 1'b1, 1'b1, SPS);
      put(0, 1'b0);
      wait_strobes("bubble_wait", base + 4, 3000);
      repeat (20) @(posedge CLK);
      check("bubble_strobe_count", strobes - base, 4);

      // Reset at sample 30, held with din_vld high, then a clean symbol
      send_sym(4'h9, UNIT, 1'b0, 1'b0, 30);
      @(posedge CLK);
      #1 Rst = 1'b1;
      bus.din_vld = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("midrst_sym", bus.sym, 0);
      check("midrst_sym_vld", bus.sym_vld, 0);
      @(posedge CLK);
      #1 Rst = 1'b0;
      bus.din_vld = 1'b0;
      base = strobes;
      first_strobe_cyc = -1;
      send_sym(4'h6, UNIT, 1'b0, 1'b1, SPS);
      t_sym = t_first;
      put(0, 1'b0);
      wait_strobes("rst_sym_wait", base + 1, 200);
      check("rst_latency", first_strobe_cyc - t_sym + 1, 68);
      repeat (10) @(posedge CLK);
      check("rst_strobe_count", strobes - base, 1);

      // I integral exactly +THR and -THR
      c0 = cos_t[0];
      c1 = cos_t[1] + cos_t[15];
      b = 0;
      while (b < c0 && ((THR - b * c1) % c0) != 0) b++;
      a = (THR - b * c1) / c0;
      base = strobes;
      send_exact(a, b, 4'b1011);
      wait_strobes("thr_pos_wait", base + 1, 200);
`ifdef QAM16_DEMOD_SOFT_EN
      @(negedge CLK);
      check("soft_i_pos", longint'(bus.soft_i), THR);
      check("soft_q_pos", longint'(bus.soft_q), 0);
`endif
      send_exact(-a, -b, 4'b0111);
      wait_strobes("thr_neg_wait", base + 2, 200);
`ifdef QAM16_DEMOD_SOFT_EN
      @(negedge CLK);
      check("soft_i_neg", longint'(bus.soft_i), -THR);
`endif
      repeat (10) @(posedge CLK);
      check("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
